// File: rtl/nasti_bram_responder_if.sv
// NASTI (AXI4) five-channel bundle between a bus master and a slave.
// Latency: none, wires only.
// Backpressure: each channel carries its own valid/ready pair.
interface nasti_bram_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    // write address channel
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;
    // write data channel
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;
    // write response channel
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;
    // read address channel
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;
    // read data channel
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/nasti_bram_responder.sv
// NASTI slave serving INCR/FIXED bursts from a word-addressed on-chip memory, one burst per direction.
// Latency: first R beat 2 cycles after AR handshake, then one beat per cycle; B one cycle after the final W beat.
// Backpressure: W is accepted only after AW; R data/last/resp hold while r_ready is low; B holds until b_ready.
module nasti_bram_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
) (
    input  logic aclk,
    input  logic aresetn,
    nasti_bram_responder_if.slave s
);
    localparam int ADDR_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam int NBYTES     = DATA_WIDTH / 8;

    // Only WRAP, the reserved burst code and non-full-width beats are rejected.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] | (size != 3'(ADDR_SHIFT));
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    w_state_t w_state, w_nxt;
    r_state_t r_state, r_nxt;

    logic aw_ready_q, w_ready_q, b_valid_q, aw_ready_d, w_ready_d, b_valid_d;
    logic ar_ready_q, r_valid_q, ar_ready_d, r_valid_d;

    logic [IDX_W-1:0]      w_idx, r_idx;
    logic [7:0]            w_len, w_cnt, r_len, r_cnt;
    logic [ID_WIDTH-1:0]   w_id, r_id;
    logic                  w_err, w_incr, r_err, r_incr;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_last_q;

    logic aw_fire, w_fire, w_done, b_fire, ar_fire, r_fire, r_done;

    assign aw_fire = s.aw_valid & aw_ready_q;
    assign w_fire  = s.w_valid & w_ready_q;
    // A burst ends on w_last or on the beat count, whichever arrives first.
    assign w_done  = w_fire & (s.w_last | (w_cnt == w_len));
    assign b_fire  = b_valid_q & s.b_ready;
    assign ar_fire = s.ar_valid & ar_ready_q;
    assign r_fire  = r_valid_q & s.r_ready;
    assign r_done  = r_fire & r_last_q;

    // Write FSM state and its registered handshake outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            w_state    <= w_nxt;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
        end
    end

    // Write FSM next-state
    always_comb begin
        w_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_nxt = W_DATA;
            W_DATA:  if (w_done)  w_nxt = W_RESP;
            W_RESP:  if (b_fire)  w_nxt = W_IDLE;
            default: w_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs, decoded from the next state so they are registered
    always_comb begin
        aw_ready_d = (w_nxt == W_IDLE);
        w_ready_d  = (w_nxt == W_DATA);
        b_valid_d  = (w_nxt == W_RESP);
    end

    // Write burst context: captured on AW, advanced per accepted W beat
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_idx  <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_id   <= '0;
            w_err  <= 1'b0;
            w_incr <= 1'b0;
        end else if (aw_fire) begin
            w_idx  <= s.aw_addr[ADDR_SHIFT +: IDX_W];
            w_len  <= s.aw_len;
            w_cnt  <= '0;
            w_id   <= s.aw_id;
            w_err  <= burst_err(s.aw_burst, s.aw_size);
            w_incr <= (s.aw_burst == 2'b01);
        end else if (w_fire) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_incr) w_idx <= w_idx + 1'b1;
        end
    end

    // Byte-lane memory write; rejected bursts are drained without touching memory
    always_ff @(posedge aclk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (w_fire && !w_err && s.w_strb[b]) mem[w_idx][8*b +: 8] <= s.w_data[8*b +: 8];
        end
    end

    // Read FSM state and its registered handshake outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
        end else begin
            r_state    <= r_nxt;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
        end
    end

    // Read FSM next-state
    always_comb begin
        r_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_nxt = R_FETCH;
            R_FETCH: r_nxt = R_DATA;
            R_DATA:  if (r_done)  r_nxt = R_IDLE;
            default: r_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs, decoded from the next state so they are registered
    always_comb begin
        ar_ready_d = (r_nxt == R_IDLE);
        r_valid_d  = (r_nxt == R_DATA);
    end

    // Read datapath: prime the first word in FETCH, then reload on every non-last handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_id     <= '0;
            r_err    <= 1'b0;
            r_incr   <= 1'b0;
            r_data_q <= '0;
            r_last_q <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_idx  <= s.ar_addr[ADDR_SHIFT +: IDX_W];
                        r_len  <= s.ar_len;
                        r_id   <= s.ar_id;
                        r_err  <= burst_err(s.ar_burst, s.ar_size);
                        r_incr <= (s.ar_burst == 2'b01);
                    end
                end
                R_FETCH: begin
                    r_data_q <= r_err ? '0 : mem[r_idx];
                    r_last_q <= (r_len == 8'd0);
                    r_cnt    <= '0;
                    if (r_incr) r_idx <= r_idx + 1'b1;
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (r_last_q) begin
                            r_last_q <= 1'b0;
                        end else begin
                            r_data_q <= r_err ? '0 : mem[r_idx];
                            r_cnt    <= r_cnt + 8'd1;
                            r_last_q <= ((r_cnt + 8'd1) == r_len);
                            if (r_incr) r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign s.aw_ready = aw_ready_q;
    assign s.w_ready  = w_ready_q;
    assign s.b_valid  = b_valid_q;
    assign s.b_id     = w_id;
    assign s.b_resp   = w_err ? 2'b10 : 2'b00;
    assign s.b_user   = '0;
    assign s.ar_ready = ar_ready_q;
    assign s.r_valid  = r_valid_q;
    assign s.r_data   = r_data_q;
    assign s.r_last   = r_last_q;
    assign s.r_id     = r_id;
    assign s.r_resp   = r_err ? 2'b10 : 2'b00;
    assign s.r_user   = '0;

    // Sideband fields and address bits outside the word index carry no meaning here.
    logic unused_sideband;
    assign unused_sideband = &{1'b0,
        s.aw_addr[ADDR_WIDTH-1:ADDR_SHIFT+IDX_W], s.aw_addr[ADDR_SHIFT-1:0],
        s.ar_addr[ADDR_WIDTH-1:ADDR_SHIFT+IDX_W], s.ar_addr[ADDR_SHIFT-1:0],
        s.aw_lock, s.aw_cache, s.aw_prot, s.aw_qos, s.aw_region, s.aw_user,
        s.ar_lock, s.ar_cache, s.ar_prot, s.ar_qos, s.ar_region, s.ar_user,
        s.w_user};
endmodule

// File: tb/tb_nasti_bram_responder.sv
// Directed bench for nasti_bram_responder: one task per scenario, inline checks.
// Drives and samples 1 time unit after each rising aclk edge.
// All waits on DUT handshakes are bounded; an expired bound is a failed check.
module tb_nasti_bram_responder;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   checks = 0;
    int   passed = 0;

    nasti_bram_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1)) bus ();

    nasti_bram_responder #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_DEPTH(1024), .ID_WIDTH(4), .USER_WIDTH(1)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s       (bus.slave)
    );

    always #5 aclk = ~aclk;

    logic [63:0] wdat [256];
    logic [7:0]  wstrb[256];
    logic [63:0] rdat [256];
    logic        rlst [256];
    logic [1:0]  rrsp [256];
    logic [3:0]  rids [256];
    logic [63:0] exp4 [256];
    int          rbeats;
    int          stall_bad;
    bit          tmo;
    logic [3:0]  bid_got;
    logic [1:0]  bresp_got;

    task automatic idle_inputs();
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = 3'd3; bus.aw_burst = 2'b01;
        bus.aw_lock = 1'b0; bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_qos = '0; bus.aw_region = '0;
        bus.aw_user = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_user = '0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = 3'd3; bus.ar_burst = 2'b01;
        bus.ar_lock = 1'b0; bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_qos = '0; bus.ar_region = '0;
        bus.ar_user = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Full write burst from wdat/wstrb; B result lands in bid_got/bresp_got.
    task automatic do_write(input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] id);
        int n;
        bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = 3'd3;
        bus.aw_burst = burst; bus.aw_id = id; bus.aw_valid = 1'b1;
        n = 0;
        while (bus.aw_ready !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) tmo = 1'b1;
        tick();
        bus.aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.w_data = wdat[i]; bus.w_strb = wstrb[i];
            bus.w_last = (i == int'(len)); bus.w_valid = 1'b1;
            n = 0;
            while (bus.w_ready !== 1'b1 && n < 100) begin tick(); n++; end
            if (n >= 100) tmo = 1'b1;
            tick();
        end
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        bus.b_ready = 1'b1;
        n = 0;
        while (bus.b_valid !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) tmo = 1'b1;
        bid_got = bus.b_id; bresp_got = bus.b_resp;
        tick();
        bus.b_ready = 1'b0;
    endtask

    // Full read burst into rdat/rlst/rrsp/rids; toggle=1 stalls every other cycle.
    task automatic do_read(input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id, input bit toggle);
        int n;
        int cyc;
        bit rr;
        bit prev_stall;
        logic [63:0] pd;
        logic pl;
        logic [1:0] pr;
        bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = 3'd3;
        bus.ar_burst = burst; bus.ar_id = id; bus.ar_valid = 1'b1;
        n = 0;
        while (bus.ar_ready !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) tmo = 1'b1;
        tick();
        bus.ar_valid = 1'b0;
        rbeats = 0; stall_bad = 0; prev_stall = 1'b0; cyc = 0;
        pd = '0; pl = 1'b0; pr = '0;
        while (rbeats <= int'(len) && cyc < 2000) begin
            rr = toggle ? (cyc % 2 == 1) : 1'b1;
            bus.r_ready = rr;
            if (prev_stall && (bus.r_data !== pd || bus.r_last !== pl || bus.r_resp !== pr)) stall_bad++;
            if (bus.r_valid === 1'b1 && rr) begin
                rdat[rbeats] = bus.r_data; rlst[rbeats] = bus.r_last;
                rrsp[rbeats] = bus.r_resp; rids[rbeats] = bus.r_id;
                rbeats++;
            end
            prev_stall = (bus.r_valid === 1'b1) && !rr;
            pd = bus.r_data; pl = bus.r_last; pr = bus.r_resp;
            tick();
            cyc++;
        end
        bus.r_ready = 1'b0;
        if (cyc >= 2000) tmo = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        aresetn = 1'b0;
        repeat (3) tick();
        checks++; if (bus.aw_ready !== 1'b0) $display("FAIL reset_aw_ready got=%b exp=0", bus.aw_ready); else passed++;
        checks++; if (bus.ar_ready !== 1'b0) $display("FAIL reset_ar_ready got=%b exp=0", bus.ar_ready); else passed++;
        checks++; if (bus.w_ready !== 1'b0) $display("FAIL reset_w_ready got=%b exp=0", bus.w_ready); else passed++;
        checks++; if (bus.r_valid !== 1'b0 || bus.r_last !== 1'b0 || bus.r_resp !== 2'b00)
            $display("FAIL reset_r got valid=%b last=%b resp=%b exp 0/0/00", bus.r_valid, bus.r_last, bus.r_resp); else passed++;
        checks++; if (bus.b_valid !== 1'b0 || bus.b_resp !== 2'b00)
            $display("FAIL reset_b got valid=%b resp=%b exp 0/00", bus.b_valid, bus.b_resp); else passed++;
        aresetn = 1'b1;
        #1;
        checks++; if (bus.aw_ready !== 1'b0) $display("FAIL ready_before_edge got=%b exp=0", bus.aw_ready); else passed++;
        tick();
        checks++; if (bus.aw_ready !== 1'b1 || bus.ar_ready !== 1'b1)
            $display("FAIL ready_after_release got aw=%b ar=%b exp 1/1", bus.aw_ready, bus.ar_ready); else passed++;
    endtask

    task automatic test_incr_write_read();
        tmo = 1'b0;
        wdat[0] = 64'h11; wdat[1] = 64'h22; wdat[2] = 64'h33; wdat[3] = 64'h44;
        for (int i = 0; i < 4; i++) wstrb[i] = 8'hFF;
        do_write(64'h100, 8'd3, 2'b01, 4'd5);
        checks++; if (bid_got !== 4'd5 || bresp_got !== 2'b00)
            $display("FAIL t1_b got id=%0d resp=%b exp id=5 resp=00", bid_got, bresp_got); else passed++;
        do_read(64'h100, 8'd3, 2'b01, 4'd9, 1'b0);
        checks++; if (rbeats !== 4) $display("FAIL t1_beats got=%0d exp=4", rbeats); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rdat[i] !== wdat[i]) $display("FAIL t1_data beat %0d got=%h exp=%h", i, rdat[i], wdat[i]); else passed++;
            checks++; if (rlst[i] !== (i == 3)) $display("FAIL t1_last beat %0d got=%b exp=%b", i, rlst[i], (i == 3)); else passed++;
        end
        checks++; if (rids[0] !== 4'd9 || rrsp[0] !== 2'b00)
            $display("FAIL t1_rid got id=%0d resp=%b exp id=9 resp=00", rids[0], rrsp[0]); else passed++;
        checks++; if (tmo !== 1'b0) $display("FAIL t1_timeout got=%b exp=0", tmo); else passed++;
    endtask

    task automatic test_strobe();
        tmo = 1'b0;
        wdat[0] = 64'h0123456789ABCDEF; wstrb[0] = 8'hFF;
        do_write(64'h200, 8'd0, 2'b01, 4'd1);
        wdat[0] = 64'hFFFFFFFFFFFFFFFF; wstrb[0] = 8'h0F;
        do_write(64'h200, 8'd0, 2'b01, 4'd2);
        do_read(64'h200, 8'd0, 2'b01, 4'd3, 1'b0);
        checks++; if (rdat[0] !== 64'h01234567FFFFFFFF)
            $display("FAIL t2_strobe got=%h exp=01234567ffffffff", rdat[0]); else passed++;
        checks++; if (rlst[0] !== 1'b1) $display("FAIL t2_last got=%b exp=1", rlst[0]); else passed++;
        checks++; if (tmo !== 1'b0) $display("FAIL t2_timeout got=%b exp=0", tmo); else passed++;
    endtask

    task automatic test_read_backpressure();
        tmo = 1'b0;
        for (int i = 0; i < 8; i++) begin wdat[i] = 64'hA0A0_0000_0000_0000 | 64'(i * 17 + 1); wstrb[i] = 8'hFF; end
        do_write(64'h400, 8'd7, 2'b01, 4'd4);
        do_read(64'h400, 8'd7, 2'b01, 4'd6, 1'b1);
        checks++; if (rbeats !== 8) $display("FAIL t3_beats got=%0d exp=8", rbeats); else passed++;
        checks++; if (stall_bad !== 0) $display("FAIL t3_stall_stable got=%0d changes exp=0", stall_bad); else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rdat[i] !== (64'hA0A0_0000_0000_0000 | 64'(i * 17 + 1)))
                $display("FAIL t3_data beat %0d got=%h", i, rdat[i]); else passed++;
            checks++; if (rlst[i] !== (i == 7)) $display("FAIL t3_last beat %0d got=%b exp=%b", i, rlst[i], (i == 7)); else passed++;
        end
        checks++; if (tmo !== 1'b0) $display("FAIL t3_timeout got=%b exp=0", tmo); else passed++;
    endtask

    task automatic test_wrap_around();
        int bad;
        tmo = 1'b0;
        for (int i = 0; i < 256; i++) begin
            exp4[i] = {16'hF00D, 16'(i), 16'(~i), 16'(i * 7)};
            wdat[i] = exp4[i]; wstrb[i] = 8'hFF;
        end
        do_write(64'h1FE0, 8'd255, 2'b01, 4'd7);
        checks++; if (bresp_got !== 2'b00) $display("FAIL t4_bresp got=%b exp=00", bresp_got); else passed++;
        do_read(64'h0, 8'd251, 2'b01, 4'd8, 1'b0);
        checks++; if (rbeats !== 252) $display("FAIL t4_low_beats got=%0d exp=252", rbeats); else passed++;
        bad = 0;
        for (int k = 0; k < 252; k++) if (rdat[k] !== exp4[k + 4]) bad++;
        checks++; if (bad !== 0) $display("FAIL t4_low_data got=%0d bad beats exp=0 (beat0 got=%h exp=%h)", bad, rdat[0], exp4[4]); else passed++;
        do_read(64'h1FE0, 8'd255, 2'b01, 4'd8, 1'b0);
        checks++; if (rbeats !== 256) $display("FAIL t4_full_beats got=%0d exp=256", rbeats); else passed++;
        bad = 0;
        for (int k = 0; k < 256; k++) if (rdat[k] !== exp4[k] || rlst[k] !== (k == 255)) bad++;
        checks++; if (bad !== 0) $display("FAIL t4_full_data got=%0d bad beats exp=0", bad); else passed++;
        checks++; if (tmo !== 1'b0) $display("FAIL t4_timeout got=%b exp=0", tmo); else passed++;
    endtask

    task automatic test_burst_error();
        tmo = 1'b0;
        wdat[0] = 64'h1122334455667788; wstrb[0] = 8'hFF;
        do_write(64'h600, 8'd0, 2'b01, 4'd1);
        wdat[0] = 64'hDEADDEADDEADDEAD; wstrb[0] = 8'hFF;
        do_write(64'h600, 8'd0, 2'b10, 4'd12);
        checks++; if (bresp_got !== 2'b10 || bid_got !== 4'd12)
            $display("FAIL t5_bresp got resp=%b id=%0d exp resp=10 id=12", bresp_got, bid_got); else passed++;
        do_read(64'h600, 8'd0, 2'b01, 4'd2, 1'b0);
        checks++; if (rdat[0] !== 64'h1122334455667788) $display("FAIL t5_mem_kept got=%h exp=1122334455667788", rdat[0]); else passed++;
        do_read(64'h600, 8'd2, 2'b10, 4'd3, 1'b0);
        checks++; if (rbeats !== 3) $display("FAIL t5_err_beats got=%0d exp=3", rbeats); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rrsp[i] !== 2'b10 || rdat[i] !== 64'h0 || rlst[i] !== (i == 2))
                $display("FAIL t5_err_beat %0d got resp=%b data=%h last=%b", i, rrsp[i], rdat[i], rlst[i]); else passed++;
        end
        checks++; if (tmo !== 1'b0) $display("FAIL t5_timeout got=%b exp=0", tmo); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        int n;
        tmo = 1'b0;
        for (int i = 0; i < 16; i++) begin wdat[i] = {32'h5A5A0000, 32'(i)}; wstrb[i] = 8'hFF; end
        do_write(64'h800, 8'd15, 2'b01, 4'd0);
        n = 0;
        while ((bus.aw_ready !== 1'b1 || bus.ar_ready !== 1'b1) && n < 100) begin tick(); n++; end
        if (n >= 100) tmo = 1'b1;
        bus.aw_addr = 64'h800; bus.aw_len = 8'd15; bus.aw_burst = 2'b01; bus.aw_id = 4'd3; bus.aw_valid = 1'b1;
        bus.ar_addr = 64'h800; bus.ar_len = 8'd15; bus.ar_burst = 2'b01; bus.ar_id = 4'd4; bus.ar_valid = 1'b1;
        tick();
        bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
        bus.w_data = {32'hBEEF0000, 32'd0}; bus.w_strb = 8'hFF; bus.w_last = 1'b0; bus.w_valid = 1'b1;
        bus.r_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.w_data = {32'hBEEF0000, 32'(i + 1)};
        end
        checks++; if (bus.r_valid !== 1'b1 || bus.w_ready !== 1'b1)
            $display("FAIL t6_mid_burst got r_valid=%b w_ready=%b exp 1/1", bus.r_valid, bus.w_ready); else passed++;
        aresetn = 1'b0;
        #1;
        checks++; if (bus.r_valid !== 1'b0 || bus.b_valid !== 1'b0 || bus.w_ready !== 1'b0 ||
                      bus.aw_ready !== 1'b0 || bus.ar_ready !== 1'b0)
            $display("FAIL t6_reset_drop got r_valid=%b b_valid=%b w_ready=%b aw_ready=%b ar_ready=%b exp all 0",
                     bus.r_valid, bus.b_valid, bus.w_ready, bus.aw_ready, bus.ar_ready); else passed++;
        idle_inputs();
        tick();
        aresetn = 1'b1;
        tick();
        do_read(64'h800, 8'd5, 2'b01, 4'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (rdat[i] !== {32'hBEEF0000, 32'(i)})
                $display("FAIL t6_partial beat %0d got=%h exp=beef0000%08h", i, rdat[i], i); else passed++;
        end
        checks++; if (rdat[5] !== {32'h5A5A0000, 32'd5}) $display("FAIL t6_untouched got=%h exp=5a5a000000000005", rdat[5]); else passed++;
        wdat[0] = 64'h0F0F_1234_5678_F0F0; wstrb[0] = 8'hFF;
        do_write(64'h900, 8'd0, 2'b01, 4'd10);
        checks++; if (bid_got !== 4'd10 || bresp_got !== 2'b00)
            $display("FAIL t6_fresh_b got id=%0d resp=%b exp id=10 resp=00", bid_got, bresp_got); else passed++;
        do_read(64'h900, 8'd0, 2'b01, 4'd11, 1'b0);
        checks++; if (rdat[0] !== 64'h0F0F_1234_5678_F0F0 || rlst[0] !== 1'b1 || rids[0] !== 4'd11)
            $display("FAIL t6_fresh_r got data=%h last=%b id=%0d exp 0f0f12345678f0f0/1/11", rdat[0], rlst[0], rids[0]); else passed++;
        checks++; if (tmo !== 1'b0) $display("FAIL t6_timeout got=%b exp=0", tmo); else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=expired exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_incr_write_read();
        test_strobe();
        test_read_backpressure();
        test_wrap_around();
        test_burst_error();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
